// File: rtl/dk_discrete_mixer.sv
// dk_discrete_mixer: sequential mixer for the discrete sound generators.
// On each audio_clk_en strobe every channel is snapshotted. One shared
// multiplier then applies a fixed per-channel gain, one channel per cycle,
// and the saturated sum is presented on out with a one-cycle out_valid pulse.
// Optional feature macro: DK_MIXER_DC_BLOCK_EN adds a one-pole DC blocker
// stage (DCB) between saturation and the output register.
module dk_discrete_mixer #(
    parameter int NUM_CHANNELS = 4,
    parameter int GAIN_WIDTH   = 8,
    parameter logic [NUM_CHANNELS*GAIN_WIDTH-1:0] GAINS = {4{8'h80}},
    parameter int DC_SHIFT     = 10
) (
    input  logic                       clk,
    input  logic                       I_RST,
    input  logic                       audio_clk_en,
    input  logic [NUM_CHANNELS*16-1:0] in_samples,
    output logic [15:0]                out,
    output logic                       out_valid,
    output logic                       overrun
);

    localparam int CNT_W  = $clog2(NUM_CHANNELS);
    localparam int IDX_W  = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
    localparam int PROD_W = 16 + GAIN_WIDTH + 1;
    localparam int ACC_W  = 16 + GAIN_WIDTH + 1 + CNT_W;

    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(32767);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-32768);

`ifdef DK_MIXER_DC_BLOCK_EN
    typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_SAT, S_DCB} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_SAT} state_t;
`endif

    state_t state_reg;
    state_t state_next;

    logic signed [15:0]       snap_reg [NUM_CHANNELS];
    logic [GAIN_WIDTH-1:0]    gain_arr [NUM_CHANNELS];
    logic signed [ACC_W-1:0]  acc_reg;
    logic [IDX_W-1:0]         idx_reg;

    logic                     start;
    logic                     idx_last;
    logic signed [15:0]       cur_sample;
    logic [GAIN_WIDTH-1:0]    cur_gain;
    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W-1:0]  scaled;
    logic signed [15:0]       sat_val;

    assign start    = (state_reg == S_IDLE) && audio_clk_en;
    assign idx_last = (idx_reg == IDX_W'(NUM_CHANNELS - 1));

    // Per-channel snapshot registers and unpacked view of the gain vector
    genvar gi;
    generate
        for (gi = 0; gi < NUM_CHANNELS; gi++) begin : g_chan
            assign gain_arr[gi] = GAINS[gi*GAIN_WIDTH +: GAIN_WIDTH];

            // Capture this channel only when a strobe is accepted in IDLE
            always_ff @(posedge clk or posedge I_RST) begin
                if (I_RST) begin
                    snap_reg[gi] <= '0;
                end else if (start) begin
                    snap_reg[gi] <= in_samples[gi*16 +: 16];
                end
            end
        end
    endgenerate

    // Shared multiplier: signed sample times zero-extended (unsigned) gain
    assign cur_sample = snap_reg[idx_reg];
    assign cur_gain   = gain_arr[idx_reg];
    assign prod       = PROD_W'(cur_sample) * $signed(PROD_W'({1'b0, cur_gain}));

    // Rescale from Q1.(GAIN_WIDTH-1) (floor) and clamp to 16-bit signed range
    always_comb begin
        scaled  = acc_reg >>> (GAIN_WIDTH - 1);
        sat_val = scaled[15:0];
        if (scaled > SAT_MAX) begin
            sat_val = 16'sh7FFF;
        end else if (scaled < SAT_MIN) begin
            sat_val = 16'sh8000;
        end
    end

    // State register
    always_ff @(posedge clk or posedge I_RST) begin
        if (I_RST) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic: IDLE -> ACCUM (N cycles) -> SAT [-> DCB] -> IDLE
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:  if (audio_clk_en) state_next = S_ACCUM;
            S_ACCUM: if (idx_last) state_next = S_SAT;
`ifdef DK_MIXER_DC_BLOCK_EN
            S_SAT:   state_next = S_DCB;
            S_DCB:   state_next = S_IDLE;
`else
            S_SAT:   state_next = S_IDLE;
`endif
            default: state_next = S_IDLE;
        endcase
    end

    // Accumulator and channel index; the accumulator is wide enough never to wrap
    always_ff @(posedge clk or posedge I_RST) begin
        if (I_RST) begin
            acc_reg <= '0;
            idx_reg <= '0;
        end else if (start) begin
            acc_reg <= '0;
            idx_reg <= '0;
        end else if (state_reg == S_ACCUM) begin
            acc_reg <= acc_reg + ACC_W'(prod);
            idx_reg <= idx_reg + IDX_W'(1);
        end
    end

    // Sticky overrun: a strobe seen in any state other than IDLE is dropped
    always_ff @(posedge clk or posedge I_RST) begin
        if (I_RST) begin
            overrun <= 1'b0;
        end else if (audio_clk_en && (state_reg != S_IDLE)) begin
            overrun <= 1'b1;
        end
    end

`ifdef DK_MIXER_DC_BLOCK_EN
    logic signed [15:0] x_reg;
    logic signed [15:0] x_prev_reg;
    logic signed [31:0] y_prev_reg;
    logic signed [31:0] y_next;
    logic signed [15:0] y_sat;

    // One-pole high-pass: y = x - x_prev + y_prev - y_prev/2^DC_SHIFT
    always_comb begin
        y_next = 32'(x_reg) - 32'(x_prev_reg) + y_prev_reg - (y_prev_reg >>> DC_SHIFT);
        y_sat  = y_next[15:0];
        if (y_next > 32'sd32767) begin
            y_sat = 16'sh7FFF;
        end else if (y_next < -32'sd32768) begin
            y_sat = 16'sh8000;
        end
    end

    // Hold the saturated mix for one cycle, then filter it; y_prev keeps full precision
    always_ff @(posedge clk or posedge I_RST) begin
        if (I_RST) begin
            x_reg      <= '0;
            x_prev_reg <= '0;
            y_prev_reg <= '0;
        end else if (state_reg == S_SAT) begin
            x_reg <= sat_val;
        end else if (state_reg == S_DCB) begin
            x_prev_reg <= x_reg;
            y_prev_reg <= y_next;
        end
    end

    // Output register: updated and pulsed from the DCB stage
    always_ff @(posedge clk or posedge I_RST) begin
        if (I_RST) begin
            out       <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            if (state_reg == S_DCB) begin
                out       <= y_sat;
                out_valid <= 1'b1;
            end
        end
    end
`else
    // Output register: updated and pulsed directly from the SAT stage
    always_ff @(posedge clk or posedge I_RST) begin
        if (I_RST) begin
            out       <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            if (state_reg == S_SAT) begin
                out       <= sat_val;
                out_valid <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_dk_discrete_mixer.sv
// Scoreboard bench for dk_discrete_mixer (default build, no DC blocker).
// Two instances share the stimulus: one with unity gains, one with
// gains {8'h40,8'h80,8'hFF,8'h00} (channel 3..0).
module tb_dk_discrete_mixer;

    localparam int N = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en  = 1'b0;
    logic [63:0] in_s = '0;
    logic [15:0] out_u, out_g;
    logic        v_u, v_g, ov_u, ov_g;

    dk_discrete_mixer #(
        .NUM_CHANNELS(N), .GAIN_WIDTH(8), .GAINS({4{8'h80}}), .DC_SHIFT(10)
    ) dut_u (
        .clk(clk), .I_RST(rst), .audio_clk_en(en), .in_samples(in_s),
        .out(out_u), .out_valid(v_u), .overrun(ov_u)
    );

    dk_discrete_mixer #(
        .NUM_CHANNELS(N), .GAIN_WIDTH(8), .GAINS({8'h40, 8'h80, 8'hFF, 8'h00}), .DC_SHIFT(10)
    ) dut_g (
        .clk(clk), .I_RST(rst), .audio_clk_en(en), .in_samples(in_s),
        .out(out_g), .out_valid(v_g), .overrun(ov_g)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        int val;
        int at;
    } exp_t;

    exp_t q_u[$];
    exp_t q_g[$];

    int vectors     = 0;
    int miscompares = 0;

    int gains_u[4] = '{128, 128, 128, 128};
    int gains_g[4] = '{0, 255, 128, 64};

    // Reference: exact weighted sum, floor-divide by 128, clamp to 16 bits
    function automatic int ref_mix(input logic [63:0] s, input int g[4]);
        longint sum;
        sum = 0;
        for (int i = 0; i < 4; i++) begin
            logic signed [15:0] ch;
            ch = s[i*16 +: 16];
            sum += longint'(ch) * longint'(g[i]);
        end
        sum = sum >>> 7;
        if (sum > 32767) sum = 32767;
        if (sum < -32768) sum = -32768;
        return int'(sum);
    endfunction

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitors: pop and compare whenever a DUT presents a sample
    always @(negedge clk) begin
        if (v_u) begin
            if (q_u.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_valid_u: got out=%0d, expected no pulse (cycle %0d)",
                         $signed(out_u), cyc);
            end else begin
                exp_t e;
                e = q_u.pop_front();
                $display("txn unity: out=%0d exp=%0d cycle=%0d", $signed(out_u), e.val, cyc);
                check("mix_unity", int'($signed(out_u)), e.val);
                check("latency_unity", cyc, e.at);
            end
        end
    end

    always @(negedge clk) begin
        if (v_g) begin
            if (q_g.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_valid_g: got out=%0d, expected no pulse (cycle %0d)",
                         $signed(out_g), cyc);
            end else begin
                exp_t e;
                e = q_g.pop_front();
                $display("txn gained: out=%0d exp=%0d cycle=%0d", $signed(out_g), e.val, cyc);
                check("mix_gained", int'($signed(out_g)), e.val);
                check("latency_gained", cyc, e.at);
            end
        end
    end

    // One strobe; spacing = cycles until the next strobe may be driven (>= 2).
    // Inputs are scrambled after the strobe to show only the snapshot matters.
    task automatic strobe(input logic [63:0] s, input bit expect_out, input int spacing);
        exp_t e;
        @(posedge clk);
        #1;
        in_s = s;
        en   = 1'b1;
        if (expect_out) begin
            e.at  = cyc + N + 2;
            e.val = ref_mix(s, gains_u);
            q_u.push_back(e);
            e.val = ref_mix(s, gains_g);
            q_g.push_back(e);
        end
        @(posedge clk);
        #1;
        en   = 1'b0;
        in_s = {$urandom, $urandom};
        repeat (spacing - 2) @(posedge clk);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("rst_out_u", int'(out_u), 0);
        check("rst_out_g", int'(out_g), 0);
        check("rst_ovr_u", int'(ov_u), 0);
        check("rst_ovr_g", int'(ov_g), 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        logic [63:0] s;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("init_out_u", int'(out_u), 0);
        check("init_valid_u", int'(v_u), 0);
        check("init_ovr_u", int'(ov_u), 0);
        check("init_out_g", int'(out_g), 0);
        rst = 1'b0;

        // Reset two cycles into ACCUM: no result may ever appear
        strobe({4{16'd5000}}, 1'b0, 2);
        do_reset();
        repeat (8) @(posedge clk);

        // Directed vectors at minimum spacing
        strobe({16'd0, 16'd300, 16'hFF38, 16'd1000}, 1'b1, N + 2);
        strobe({4{16'd1000}}, 1'b1, N + 2);
        strobe({4{16'h7FFF}}, 1'b1, N + 2);
        strobe({4{16'h8000}}, 1'b1, N + 2);
        strobe({16'd0, 16'd0, 16'd0, 16'hFFFF}, 1'b1, N + 2);
        repeat (4) @(posedge clk);
        #1;
        check("no_overrun_min_spacing", int'(ov_u), 0);

        // Overrun: second strobe 3 cycles after the first is dropped
        strobe({16'd1, 16'd2, 16'd3, 16'd4}, 1'b1, 3);
        strobe({4{16'd9999}}, 1'b0, N + 2);
        #1;
        check("overrun_set_u", int'(ov_u), 1);
        check("overrun_set_g", int'(ov_g), 1);
        strobe({16'd10, 16'd20, 16'd30, 16'd40}, 1'b1, N + 2);
        repeat (3) @(posedge clk);
        #1;
        check("overrun_sticky", int'(ov_u), 1);
        do_reset();

        // Strobe landing in the SAT cycle is also dropped
        strobe({16'd7, 16'd7, 16'd7, 16'd7}, 1'b1, N + 1);
        strobe({4{16'd1234}}, 1'b0, N + 2);
        #1;
        check("overrun_sat_cycle", int'(ov_u), 1);
        do_reset();

        // Randomized traffic
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 3))
                0:       s = {4{16'h7FF0 | 16'($urandom_range(0, 15))}};
                1:       s = {4{16'h8000 | 16'($urandom_range(0, 15))}};
                default: s = {$urandom, $urandom};
            endcase
            strobe(s, 1'b1, $urandom_range(N + 2, N + 5));
        end

        // Drain: every expected sample must have been presented
        repeat (N + 10) @(posedge clk);
        check("drain_unity", q_u.size(), 0);
        check("drain_gained", q_g.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
